// File: rtl/serial_comparator.sv
// serial_comparator: digit-serial MSB-first magnitude comparator with early termination
module serial_comparator #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 Start,
  input  logic [WIDTH-1:0]                     A,
  input  logic [WIDTH-1:0]                     B,
  input  logic                                 Signed,
  output logic                                 Busy,
  output logic                                 Done,
  output logic                                 Lt,
  output logic                                 Gt,
  output logic                                 Eq,
  output logic [$clog2(WIDTH/DIGIT):0]         Cycles
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW = $clog2(NDIG) + 1;
  typedef enum logic [1:0] {IDLE, COMPARE, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] sa, sb;
  logic sg;
  logic [CW-1:0] cnt;
  logic [DIGIT-1:0] msk, da, db;
  logic last;
  // current digit pair; the sign bit is flipped on the leading digit so signed order matches unsigned order
  always_comb begin
    msk = (sg && cnt == '0) ? ({DIGIT{1'b1}} ^ ({DIGIT{1'b1}} >> 1)) : '0;
    da = sa[WIDTH-1 -: DIGIT] ^ msk;
    db = sb[WIDTH-1 -: DIGIT] ^ msk;
    last = cnt == CW'(NDIG - 1);
  end
  // control FSM with registered status and result outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      Busy <= 1'b0;
      Done <= 1'b0;
      Lt <= 1'b0;
      Gt <= 1'b0;
      Eq <= 1'b0;
      Cycles <= '0;
      cnt <= '0;
    end else begin
      case (state)
        COMPARE: begin
          if (da != db || last) begin
            state <= DONE;
            Busy <= 1'b0;
            Done <= 1'b1;
            Lt <= da < db;
            Gt <= da > db;
            Eq <= da == db;
            Cycles <= cnt + CW'(1);
          end else begin
            cnt <= cnt + CW'(1);
            sa <= sa << DIGIT;
            sb <= sb << DIGIT;
          end
        end
        default: begin
          Done <= 1'b0;
          Busy <= Start;
          state <= Start ? COMPARE : IDLE;
          if (Start) begin
            sa <= A;
            sb <= B;
            sg <= Signed;
            cnt <= '0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_comparator.sv
// tb_serial_comparator: randomized and directed checks of serial_comparator against an arithmetic model
module tb_serial_comparator;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start1 = 1'b0, start4 = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic sg = 1'b0;
  logic busy1, done1, lt1, gt1, eq1;
  logic busy4, done4, lt4, gt4, eq4;
  logic [3:0] cyc1;
  logic [1:0] cyc4;
  int errors = 0;
  int checks = 0;

  serial_comparator #(.WIDTH(8), .DIGIT(1)) d1 (
    .clk(clk), .reset(reset), .Start(start1), .A(a), .B(b), .Signed(sg),
    .Busy(busy1), .Done(done1), .Lt(lt1), .Gt(gt1), .Eq(eq1), .Cycles(cyc1)
  );
  serial_comparator #(.WIDTH(8), .DIGIT(4)) d4 (
    .clk(clk), .reset(reset), .Start(start4), .A(a), .B(b), .Signed(sg),
    .Busy(busy4), .Done(done4), .Lt(lt4), .Gt(gt4), .Eq(eq4), .Cycles(cyc4)
  );

  always #5 clk = ~clk;

  function automatic logic bsy(input int w);
    return w != 0 ? busy4 : busy1;
  endfunction
  function automatic logic dn(input int w);
    return w != 0 ? done4 : done1;
  endfunction
  function automatic logic [2:0] res(input int w);
    return w != 0 ? {lt4, gt4, eq4} : {lt1, gt1, eq1};
  endfunction
  function automatic int rcyc(input int w);
    return w != 0 ? int'(cyc4) : int'(cyc1);
  endfunction

  // reference: result from plain signed/unsigned arithmetic, latency from the first differing digit
  function automatic void model(input int dig, input logic [7:0] x, input logic [7:0] y,
                                input logic s, output int k, output logic [2:0] r);
    int nd;
    int m;
    nd = 8 / dig;
    m = (1 << dig) - 1;
    k = nd;
    for (int i = nd - 1; i >= 0; i--)
      if (((int'(x) >> (8 - (i + 1) * dig)) & m) != ((int'(y) >> (8 - (i + 1) * dig)) & m)) k = i + 1;
    r[2] = s ? ($signed(x) < $signed(y)) : (x < y);
    r[1] = s ? ($signed(x) > $signed(y)) : (x > y);
    r[0] = x == y;
  endfunction

  // drive one operation and measure edges from acceptance to Done; bad counts Busy/Done protocol slips
  task automatic do_op(input int w, input logic [7:0] x, input logic [7:0] y, input logic s,
                       output int k, output int bad);
    bad = 0;
    k = 0;
    @(negedge clk);
    a = x; b = y; sg = s;
    if (w != 0) start4 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; start4 = 1'b0;
    if (!bsy(w) || dn(w)) bad++;
    while (k < 100) begin
      @(negedge clk);
      k++;
      if (dn(w)) break;
      if (!bsy(w)) bad++;
    end
    if (dn(w) && bsy(w)) bad++;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy1, done1, lt1, gt1, eq1, cyc1} !== 9'b0) begin
      errors++;
      $display("FAIL reset_d1: got %b, want 0", {busy1, done1, lt1, gt1, eq1, cyc1});
    end
    checks++;
    if ({busy4, done4, lt4, gt4, eq4, cyc4} !== 7'b0) begin
      errors++;
      $display("FAIL reset_d4: got %b, want 0", {busy4, done4, lt4, gt4, eq4, cyc4});
    end
    a = 8'h80; b = 8'h7F; start1 = 1'b1;
    @(negedge clk);
    reset = 1'b0; start1 = 1'b0;
    checks++;
    if (busy1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_priority: busy=%b, want 0", busy1);
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({busy1, done1} !== 2'b00) begin
      errors++;
      $display("FAIL reset_discard: busy/done=%b, want 00", {busy1, done1});
    end
  endtask

  task automatic test_directed;
    logic [7:0] xs [4] = '{8'h80, 8'h80, 8'h5A, 8'h12};
    logic [7:0] ys [4] = '{8'h7F, 8'h7F, 8'h5A, 8'h13};
    logic ss [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    int ks [4] = '{1, 1, 8, 8};
    logic [2:0] rs [4] = '{3'b010, 3'b100, 3'b001, 3'b100};
    int k, bad;
    for (int i = 0; i < 4; i++) begin
      do_op(0, xs[i], ys[i], ss[i], k, bad);
      checks++;
      if (k !== ks[i]) begin
        errors++;
        $display("FAIL directed%0d_latency: got %0d, want %0d", i, k, ks[i]);
      end
      checks++;
      if (res(0) !== rs[i] || rcyc(0) !== ks[i]) begin
        errors++;
        $display("FAIL directed%0d_result: ltgteq=%b cycles=%0d, want %b %0d", i, res(0), rcyc(0), rs[i], ks[i]);
      end
      checks++;
      if (bad !== 0) begin
        errors++;
        $display("FAIL directed%0d_busy: %0d slips, want 0", i, bad);
      end
    end
  endtask

  task automatic test_hold;
    int k, bad;
    do_op(0, 8'h80, 8'h7F, 1'b0, k, bad);
    repeat (3) @(negedge clk);
    checks++;
    if ({busy1, done1, lt1, gt1, eq1, cyc1} !== {5'b00010, 4'd1}) begin
      errors++;
      $display("FAIL hold_idle: got %b, want 000100001", {busy1, done1, lt1, gt1, eq1, cyc1});
    end
    a = 8'h33; b = 8'h33; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy1, lt1, gt1, eq1, cyc1} !== {4'b1010, 4'd1}) begin
      errors++;
      $display("FAIL hold_compare: got %b, want 101000001", {busy1, lt1, gt1, eq1, cyc1});
    end
    k = 0;
    while (!done1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k !== 7 || {lt1, gt1, eq1} !== 3'b001) begin
      errors++;
      $display("FAIL hold_finish: k=%0d ltgteq=%b, want 7 001", k, {lt1, gt1, eq1});
    end
  endtask

  task automatic test_ignore;
    int k;
    @(negedge clk);
    a = 8'hA5; b = 8'hA7; sg = 1'b0; start4 = 1'b1;
    @(negedge clk);
    a = 8'h00;
    k = 0;
    while (k < 20) begin
      @(negedge clk);
      start4 = 1'b0;
      k++;
      if (done4) break;
    end
    checks++;
    if (k !== 2) begin
      errors++;
      $display("FAIL ignore_latency: got %0d, want 2", k);
    end
    checks++;
    if ({lt4, gt4, eq4, cyc4} !== {3'b100, 2'd2}) begin
      errors++;
      $display("FAIL ignore_result: got %b, want 10010", {lt4, gt4, eq4, cyc4});
    end
  endtask

  task automatic test_abort;
    int k, bad;
    @(negedge clk);
    a = 8'h01; b = 8'h00; sg = 1'b0; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (done1) bad++;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({busy1, done1, lt1, gt1, eq1, cyc1} !== 9'b0) begin
      errors++;
      $display("FAIL abort_clear: got %b, want 0", {busy1, done1, lt1, gt1, eq1, cyc1});
    end
    repeat (10) begin
      @(negedge clk);
      if (done1 || busy1) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL abort_no_done: %0d stray cycles, want 0", bad);
    end
    do_op(0, 8'h03, 8'h03, 1'b0, k, bad);
    checks++;
    if (k !== 8 || {lt1, gt1, eq1} !== 3'b001 || cyc1 !== 4'd8) begin
      errors++;
      $display("FAIL abort_restart: k=%0d ltgteq=%b cycles=%0d, want 8 001 8", k, {lt1, gt1, eq1}, cyc1);
    end
  endtask

  task automatic test_back_to_back;
    int k;
    @(negedge clk);
    a = 8'h80; b = 8'h00; sg = 1'b0; start1 = 1'b1;
    @(negedge clk);
    a = 8'h0F; b = 8'h0E;
    @(negedge clk);
    checks++;
    if ({done1, gt1} !== 2'b11) begin
      errors++;
      $display("FAIL b2b_first: done/gt=%b, want 11", {done1, gt1});
    end
    @(negedge clk);
    start1 = 1'b0;
    checks++;
    if ({busy1, done1} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_no_gap: busy/done=%b, want 10", {busy1, done1});
    end
    k = 0;
    while (k < 20) begin
      @(negedge clk);
      k++;
      if (done1) break;
    end
    checks++;
    if (k !== 8 || {lt1, gt1, eq1} !== 3'b010 || cyc1 !== 4'd8) begin
      errors++;
      $display("FAIL b2b_second: k=%0d ltgteq=%b cycles=%0d, want 8 010 8", k, {lt1, gt1, eq1}, cyc1);
    end
  endtask

  task automatic test_random;
    int k, ek, bad;
    logic [7:0] x, y;
    logic s;
    logic [2:0] er;
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 30; i++) begin
        x = 8'($urandom);
        case ($urandom_range(0, 3))
          0: y = x;
          1: y = x ^ (8'h01 << $urandom_range(0, 7));
          default: y = 8'($urandom);
        endcase
        s = 1'($urandom);
        model(w != 0 ? 4 : 1, x, y, s, ek, er);
        do_op(w, x, y, s, k, bad);
        checks++;
        if (k !== ek || bad !== 0) begin
          errors++;
          $display("FAIL rand_d%0d_%0d_timing: k=%0d slips=%0d, want %0d 0 (a=%h b=%h s=%b)", w, i, k, bad, ek, x, y, s);
        end
        checks++;
        if (res(w) !== er || rcyc(w) !== ek) begin
          errors++;
          $display("FAIL rand_d%0d_%0d_result: ltgteq=%b cycles=%0d, want %b %0d (a=%h b=%h s=%b)", w, i, res(w), rcyc(w), er, ek, x, y, s);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_hold;
    test_ignore;
    test_abort;
    test_back_to_back;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors + 1);
    $fatal(1);
  end
endmodule
